kldiv_batch_sched: RTL

Sequencing controller for the KL-divergence reduction datapath. It issues every (row, column) element index of a BATCH x DIM input pair to a shared pointwise term unit, which computes target*(log target − log pred). It bounds the number of in-flight requests with a credit counter and accumulates the returned terms in order. It then produces the batchmean loss: the total sum divided by BATCH. It sits between the operator's command interface (start/done) and the pointwise unit.

---
 rtl/kldiv_batch_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kldiv_batch_sched.sv
// Sequences every (row, col) index of a BATCH x DIM pair to the pointwise term unit and sums returned terms into the batchmean loss.
// Latency: one index per cycle at best; done pulses two cycles after the last result is accepted.
// Backpressure: iss_valid holds with a stable index until iss_ready; at most MAX_OUT requests are outstanding (credit counter).
module kldiv_batch_sched #(
    parameter int DIM     = 16,
    parameter int BATCH   = 4,
    parameter int IDX_W   = 8,
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 48,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] loss,
    output logic              err,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [IDX_W-1:0]  iss_idx,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data
);

    localparam int TOTAL  = DIM * BATCH;
    localparam int SHIFT  = $clog2(BATCH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int CRED_W = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FINAL,
        S_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         iss_cnt;
    logic [CNT_W-1:0]         res_cnt;
    logic [CRED_W-1:0]        credits;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [DATA_W-1:0]        loss_sat;
    logic                     start_acc;
    logic                     issue_fire;
    logic                     res_acc;
    logic                     res_spur;
    logic                     last_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        iss_valid  = 1'b0;
        iss_idx    = '0;
        start_acc  = 1'b0;
        issue_fire = 1'b0;
        // Results only count while a request is outstanding; anything else is a protocol error.
        res_acc    = res_valid && (credits != '0) && ((state == S_RUN) || (state == S_DRAIN));
        res_spur   = res_valid && !res_acc;
        last_res   = res_acc && (res_cnt == CNT_W'(TOTAL - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                iss_valid  = (credits < CRED_W'(MAX_OUT));
                iss_idx    = iss_cnt[IDX_W-1:0];
                issue_fire = iss_valid && iss_ready;
                if (last_res) begin
                    state_nxt = S_FINAL;
                end else if (issue_fire && (iss_cnt == CNT_W'(TOTAL - 1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_res) begin
                    state_nxt = S_FINAL;
                end
            end
            S_FINAL: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divide by BATCH, then clamp anything outside the DATA_W signed range.
    assign acc_shr = acc >>> SHIFT;

    always_comb begin
        loss_sat = acc_shr[DATA_W-1:0];
        if (!((&acc_shr[ACC_W-1:DATA_W-1]) || (~|acc_shr[ACC_W-1:DATA_W-1]))) begin
            loss_sat = acc_shr[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_cnt <= '0;
            res_cnt <= '0;
            credits <= '0;
            acc     <= '0;
            loss    <= '0;
            err     <= 1'b0;
        end else begin
            if (start_acc) begin
                iss_cnt <= '0;
                res_cnt <= '0;
                credits <= '0;
                acc     <= '0;
                err     <= 1'b0;
            end else begin
                if (issue_fire) begin
                    iss_cnt <= iss_cnt + 1'b1;
                end
                if (res_acc) begin
                    acc     <= acc + {{(ACC_W-DATA_W){res_data[DATA_W-1]}}, res_data};
                    res_cnt <= res_cnt + 1'b1;
                end
                credits <= credits + {{(CRED_W-1){1'b0}}, issue_fire}
                                   - {{(CRED_W-1){1'b0}}, res_acc};
            end
            if (state == S_FINAL) begin
                loss <= loss_sat;
            end
            if (res_spur) begin
                err <= 1'b1;
            end
        end
    end

endmodule
